// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: load memop encodings and helpers.
package regfile_pkg;

    localparam int unsigned MEMOP_W = 3;

    typedef enum logic [MEMOP_W-1:0] {
        MemopLw  = 3'b000,
        MemopLb  = 3'b001,
        MemopLh  = 3'b010,
        MemopLbu = 3'b011,
        MemopLhu = 3'b100
    } memop_e;

    // Signed loads replicate the top bit of the selected byte/halfword.
    function automatic logic memop_is_signed(input logic [MEMOP_W-1:0] op);
        return (op == MemopLb) || (op == MemopLh);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two writeback ports, load issue, packed read ports and debug read.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic                   wa_en;
    logic [AW-1:0]          wa_addr;
    logic [XLEN-1:0]        wa_data;

    logic                   wl_en;
    logic [AW-1:0]          wl_addr;
    logic [XLEN-1:0]        wl_data;
    logic [MEMOP_W-1:0]     wl_memop;
    logic [1:0]             wl_off;

    logic                   iss_en;
    logic [AW-1:0]          iss_addr;

    logic [NRD*AW-1:0]      rd_addr;
    logic [NRD*XLEN-1:0]    rd_data;
    logic [NRD-1:0]         rd_busy;
    logic [AW:0]            pend_cnt;

    logic [AW-1:0]          dbg_sel;
    logic [XLEN-1:0]        dbg_data;

    modport master (
        output wa_en, wa_addr, wa_data,
        output wl_en, wl_addr, wl_data, wl_memop, wl_off,
        output iss_en, iss_addr,
        output rd_addr, dbg_sel,
        input  rd_data, rd_busy, pend_cnt, dbg_data
    );

    modport slave (
        input  wa_en, wa_addr, wa_data,
        input  wl_en, wl_addr, wl_data, wl_memop, wl_off,
        input  iss_en, iss_addr,
        input  rd_addr, dbg_sel,
        output rd_data, rd_busy, pend_cnt, dbg_data
    );

endinterface

// File: rtl/load_ext.sv
// Combinational load alignment: picks the addressed byte/halfword of a raw memory word and
// sign- or zero-extends it to XLEN.
module load_ext
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]    word,
    input  logic [MEMOP_W-1:0] memop,
    input  logic [1:0]         off,
    output logic [XLEN-1:0]    data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = word[{off[1], 4'b0000} +: 16];
        sext     = memop_is_signed(memop);
        case (memop)
            MemopLb, MemopLbu: data = {{(XLEN-8){sext & byte_sel[7]}}, byte_sel};
            MemopLh, MemopLhu: data = {{(XLEN-16){sext & half_sel[15]}}, half_sel};
            // lw and the reserved codes pass the word through untouched
            default:           data = word;
        endcase
    end

endmodule

// File: rtl/regfile_sb.sv
// Flop-based register file with ALU and load writeback ports, write bypass on all reads, and a
// per-register pending scoreboard for outstanding loads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);

    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [AW:0]     cnt_q, cnt_d;

    logic [NREG-1:0] wen;
    logic [XLEN-1:0] wdat [NREG];
    logic [XLEN-1:0] wl_ext;
    logic            wa_go, wl_go, iss_go;

    logic [AW-1:0]       rd_a [NRD];
    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;

    // Gating by rst aborts same-cycle writes/issues and keeps bypassed reads at zero in reset.
    assign wa_go  = bus.wa_en  & ~rst;
    assign wl_go  = bus.wl_en  & ~rst;
    assign iss_go = bus.iss_en & ~rst;

    load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .word  (bus.wl_data),
        .memop (bus.wl_memop),
        .off   (bus.wl_off),
        .data  (wl_ext)
    );

    // Per-register next value; port A wins over port L on an address collision.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            wen[i]  = 1'b0;
            wdat[i] = regs_q[i];
            if (i != 0) begin
                if (wa_go && (bus.wa_addr == AW'(i))) begin
                    wen[i]  = 1'b1;
                    wdat[i] = bus.wa_data;
                end else if (wl_go && (bus.wl_addr == AW'(i))) begin
                    wen[i]  = 1'b1;
                    wdat[i] = wl_ext;
                end
            end
        end
    end

    // A new issue outranks the completing load so the register stays pending.
    always_comb begin
        pend_d = pend_q;
        for (int i = 1; i < NREG; i++) begin
            if (iss_go && (bus.iss_addr == AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if (wl_go && (bus.wl_addr == AW'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wen[i]) begin
                    regs_q[i] <= wdat[i];
                end
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_a[k] = bus.rd_addr[k*AW +: AW];
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_a[k] != '0) begin
                rd_data_c[k*XLEN +: XLEN] = wdat[rd_a[k]];
                rd_busy_c[k] = pend_q[rd_a[k]] &
                               ~(wl_go && (bus.wl_addr == rd_a[k]) &&
                                 !(iss_go && (bus.iss_addr == rd_a[k])));
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.pend_cnt = cnt_q;
    assign bus.dbg_data = (bus.dbg_sel == '0) ? '0 : wdat[bus.dbg_sel];

endmodule
